// File: rtl/butterfly_stage_sequencer.sv
// Loads one block, drives size/2 in-place radix-2 butterflies through an external unit, then streams the block out.
// Latency: size load + size/2 issue + butterfly latency + size drain; every stall holds its side of the handshake stable.
module butterfly_stage_sequencer #(
    parameter int n     = 32,
    parameter int d     = 16,
    parameter int size  = 8,
    parameter int stage = 0
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          recv_val,
    output logic                                          recv_rdy,
    input  logic [n-1:0]                                  recv_r,
    input  logic [n-1:0]                                  recv_c,
    output logic                                          send_val,
    input  logic                                          send_rdy,
    output logic [n-1:0]                                  send_r,
    output logic [n-1:0]                                  send_c,
    output logic                                          bf_req_val,
    input  logic                                          bf_req_rdy,
    output logic [n-1:0]                                  bf_ar,
    output logic [n-1:0]                                  bf_ac,
    output logic [n-1:0]                                  bf_br,
    output logic [n-1:0]                                  bf_bc,
    output logic [n-1:0]                                  bf_wr,
    output logic [n-1:0]                                  bf_wc,
    input  logic                                          bf_resp_val,
    output logic                                          bf_resp_rdy,
    input  logic [n-1:0]                                  bf_cr,
    input  logic [n-1:0]                                  bf_cc,
    input  logic [n-1:0]                                  bf_dr,
    input  logic [n-1:0]                                  bf_dc,
    output logic [((size > 2) ? $clog2(size/2) : 1)-1:0] tw_idx,
    input  logic [n-1:0]                                  tw_r,
    input  logic [n-1:0]                                  tw_c
);

    localparam int AW    = $clog2(size);
    localparam int HALF  = size / 2;
    localparam int SPAN  = 1 << stage;
    localparam int TW_W  = (size > 2) ? $clog2(size/2) : 1;
    localparam int TW_SH = AW - 1 - stage;
    localparam logic [AW-1:0] POS_MASK = AW'(SPAN - 1);

    if (size < 2 || (size & (size - 1)) != 0 || stage < 0 || SPAN >= size || d < 0 || d > n)
    begin : g_bad_cfg
        $error("butterfly_stage_sequencer: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ld_cnt_q, ld_cnt_d;
    logic [AW-1:0] dr_cnt_q, dr_cnt_d;
    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] j_q, j_d;

    logic [n-1:0] buf_r_q [size];
    logic [n-1:0] buf_c_q [size];

    logic [AW-1:0] req_lo, req_hi, rsp_lo, rsp_hi;
    logic          recv_fire, send_fire, req_fire, rsp_fire;

    // Lower operand of butterfly bfi: group base (two spans per group) plus position in group.
    function automatic logic [AW-1:0] pair_lo(input logic [AW-1:0] bfi);
        logic [AW-1:0] grp;
        grp = bfi >> stage;
        return (grp << (stage + 1)) | (bfi & POS_MASK);
    endfunction

    function automatic logic [TW_W-1:0] tw_of(input logic [AW-1:0] bfi);
        return TW_W'((bfi & POS_MASK) << TW_SH);
    endfunction

    assign req_lo = pair_lo(k_q);
    assign req_hi = req_lo + AW'(SPAN);
    assign rsp_lo = pair_lo(j_q);
    assign rsp_hi = rsp_lo + AW'(SPAN);

    assign recv_fire = recv_val & recv_rdy;
    assign send_fire = send_val & send_rdy;
    assign req_fire  = bf_req_val & bf_req_rdy;
    assign rsp_fire  = bf_resp_val & bf_resp_rdy;

    always_comb begin
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        dr_cnt_d    = dr_cnt_q;
        k_d         = k_q;
        j_d         = j_q;
        recv_rdy    = 1'b0;
        send_val    = 1'b0;
        bf_req_val  = 1'b0;
        bf_resp_rdy = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                recv_rdy = 1'b1;
                if (recv_val) begin
                    if (ld_cnt_q == AW'(size - 1)) begin
                        ld_cnt_d = '0;
                        state_d  = ST_COMPUTE;
                    end else begin
                        ld_cnt_d = ld_cnt_q + AW'(1);
                    end
                end
            end
            ST_COMPUTE: begin
                bf_req_val  = (k_q < AW'(HALF));
                bf_resp_rdy = (j_q < AW'(HALF));
                if (bf_req_val && bf_req_rdy) begin
                    k_d = k_q + AW'(1);
                end
                // The last issue always precedes the last response, so clearing k here is safe.
                if (bf_resp_val && bf_resp_rdy) begin
                    if (j_q == AW'(HALF - 1)) begin
                        j_d     = '0;
                        k_d     = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        j_d = j_q + AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                send_val = 1'b1;
                if (send_rdy) begin
                    if (dr_cnt_q == AW'(size - 1)) begin
                        dr_cnt_d = '0;
                        state_d  = ST_LOAD;
                    end else begin
                        dr_cnt_d = dr_cnt_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_LOAD;
            ld_cnt_q <= '0;
            dr_cnt_q <= '0;
            k_q      <= '0;
            j_q      <= '0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            dr_cnt_q <= dr_cnt_d;
            k_q      <= k_d;
            j_q      <= j_d;
        end
    end

    // Load and response writes never coincide: bf_resp_rdy is low outside COMPUTE.
    always_ff @(posedge clk) begin
        if (recv_fire) begin
            buf_r_q[ld_cnt_q] <= recv_r;
            buf_c_q[ld_cnt_q] <= recv_c;
        end
        if (rsp_fire) begin
            buf_r_q[rsp_lo] <= bf_cr;
            buf_c_q[rsp_lo] <= bf_cc;
            buf_r_q[rsp_hi] <= bf_dr;
            buf_c_q[rsp_hi] <= bf_dc;
        end
    end

    assign bf_ar  = bf_req_val ? buf_r_q[req_lo] : '0;
    assign bf_ac  = bf_req_val ? buf_c_q[req_lo] : '0;
    assign bf_br  = bf_req_val ? buf_r_q[req_hi] : '0;
    assign bf_bc  = bf_req_val ? buf_c_q[req_hi] : '0;
    assign bf_wr  = bf_req_val ? tw_r : '0;
    assign bf_wc  = bf_req_val ? tw_c : '0;
    assign tw_idx = bf_req_val ? tw_of(k_q) : '0;

    assign send_r = send_val ? buf_r_q[dr_cnt_q] : '0;
    assign send_c = send_val ? buf_c_q[dr_cnt_q] : '0;

    logic unused_fires;
    assign unused_fires = send_fire ^ req_fire;

endmodule

// File: tb/tb_butterfly_stage_sequencer.sv
module tb_butterfly_stage_sequencer;

    localparam int N     = 32;
    localparam int D     = 16;
    localparam int SIZE  = 8;
    localparam int STAGE = 1;
    localparam int SPAN  = 1 << STAGE;
    localparam int TWW   = 2;
    localparam int NTW   = SIZE / 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           recv_val, recv_rdy;
    logic [N-1:0]   recv_r, recv_c;
    logic           send_val, send_rdy;
    logic [N-1:0]   send_r, send_c;
    logic           bf_req_val, bf_req_rdy;
    logic [N-1:0]   bf_ar, bf_ac, bf_br, bf_bc, bf_wr, bf_wc;
    logic           bf_resp_val, bf_resp_rdy;
    logic [N-1:0]   bf_cr, bf_cc, bf_dr, bf_dc;
    logic [TWW-1:0] tw_idx;
    logic [N-1:0]   tw_r, tw_c;

    logic [N-1:0] tbl_r [NTW];
    logic [N-1:0] tbl_c [NTW];
    logic [N-1:0] in_r [SIZE];
    logic [N-1:0] in_c [SIZE];
    logic [N-1:0] gold_r [SIZE];
    logic [N-1:0] gold_c [SIZE];
    logic [N-1:0] got_r [SIZE];
    logic [N-1:0] got_c [SIZE];
    int exp_ia [SIZE/2];
    int exp_ib [SIZE/2];
    int exp_tw [SIZE/2];

    int checks = 0;
    int errors = 0;
    int max_out, last_cycles, aborted;

    typedef struct {
        int           t;
        logic [N-1:0] cr, cc, dr, dc;
    } resp_t;

    assign tw_r = tbl_r[tw_idx];
    assign tw_c = tbl_c[tw_idx];

    always #5 clk = ~clk;

    butterfly_stage_sequencer #(.n(N), .d(D), .size(SIZE), .stage(STAGE)) dut (
        .clk(clk), .reset(reset),
        .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_r(recv_r), .recv_c(recv_c),
        .send_val(send_val), .send_rdy(send_rdy), .send_r(send_r), .send_c(send_c),
        .bf_req_val(bf_req_val), .bf_req_rdy(bf_req_rdy),
        .bf_ar(bf_ar), .bf_ac(bf_ac), .bf_br(bf_br), .bf_bc(bf_bc), .bf_wr(bf_wr), .bf_wc(bf_wc),
        .bf_resp_val(bf_resp_val), .bf_resp_rdy(bf_resp_rdy),
        .bf_cr(bf_cr), .bf_cc(bf_cc), .bf_dr(bf_dr), .bf_dc(bf_dc),
        .tw_idx(tw_idx), .tw_r(tw_r), .tw_c(tw_c)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Complex butterfly in Q(D): c = a + w*b, d = a - w*b.
    function automatic void bfly(input logic [N-1:0] ar, ac, br, bc, wr, wc,
                                 output logic [N-1:0] cr, cc, dr, dc);
        longint pr, pc;
        pr = (longint'($signed(wr)) * longint'($signed(br)) - longint'($signed(wc)) * longint'($signed(bc))) >>> D;
        pc = (longint'($signed(wr)) * longint'($signed(bc)) + longint'($signed(wc)) * longint'($signed(br))) >>> D;
        cr = ar + pr[N-1:0];
        cc = ac + pc[N-1:0];
        dr = ar - pr[N-1:0];
        dc = ac - pc[N-1:0];
    endfunction

    task automatic build_golden();
        int k;
        k = 0;
        for (int g = 0; g < SIZE / (2 * SPAN); g++) begin
            for (int p = 0; p < SPAN; p++) begin
                int a, b, t;
                a = g * 2 * SPAN + p;
                b = a + SPAN;
                t = p * (SIZE / (2 * SPAN));
                exp_ia[k] = a;
                exp_ib[k] = b;
                exp_tw[k] = t;
                k++;
                bfly(in_r[a], in_c[a], in_r[b], in_c[b], tbl_r[t], tbl_c[t],
                     gold_r[a], gold_c[a], gold_r[b], gold_c[b]);
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < SIZE; i++) begin
            in_r[i] = $urandom;
            in_c[i] = $urandom;
        end
        for (int i = 0; i < NTW; i++) begin
            tbl_r[i] = $urandom;
            tbl_c[i] = $urandom;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_recv_rdy", recv_rdy, 1);
        chk("rst_send_val", send_val, 0);
        chk("rst_bf_req_val", bf_req_val, 0);
        chk("rst_bf_resp_rdy", bf_resp_rdy, 0);
        chk("rst_tw_idx", tw_idx, 0);
        chk("rst_send_r", send_r, 0);
        chk("rst_send_c", send_c, 0);
        chk("rst_bf_ar", bf_ar, 0);
        chk("rst_bf_bc", bf_bc, 0);
        chk("rst_bf_wr", bf_wr, 0);
    endtask

    // One block end to end; a cycle-level butterfly unit with fixed latency lives in here.
    task automatic run_block(input int lat, input int p_recv, input int p_req, input int p_send, input int abort_out);
        resp_t q[$];
        resp_t e;
        int ld, outn, kreq, cyc;
        bit st_s, st_r;
        logic [N-1:0] sv_sr, sv_sc, sv_ar, sv_ac, sv_br, sv_bc;
        logic [TWW-1:0] sv_tw;
        ld = 0; outn = 0; kreq = 0; cyc = 0;
        st_s = 0; st_r = 0;
        max_out = 0; aborted = 0;
        build_golden();
        while (outn < SIZE) begin
            @(negedge clk);
            if (cyc >= 2000) begin
                chk("block_timeout", outn, SIZE);
                break;
            end
            if (q.size() > max_out) max_out = q.size();
            if (abort_out > 0 && q.size() >= abort_out) begin
                aborted = 1;
                return;
            end
            if (st_s) begin
                chk("send_hold_val", send_val, 1);
                chk("send_hold_r", send_r, sv_sr);
                chk("send_hold_c", send_c, sv_sc);
            end
            if (st_r) begin
                chk("req_hold_val", bf_req_val, 1);
                chk("req_hold_tw", tw_idx, sv_tw);
                chk("req_hold_ar", bf_ar, sv_ar);
                chk("req_hold_ac", bf_ac, sv_ac);
                chk("req_hold_br", bf_br, sv_br);
                chk("req_hold_bc", bf_bc, sv_bc);
            end
            recv_val = (ld < SIZE) && ($urandom_range(99) < p_recv);
            recv_r   = recv_val ? in_r[ld] : $urandom;
            recv_c   = recv_val ? in_c[ld] : $urandom;
            if (recv_val && recv_rdy) ld++;
            if (q.size() > 0 && q[0].t <= cyc) begin
                bf_resp_val = 1'b1;
                bf_cr = q[0].cr; bf_cc = q[0].cc; bf_dr = q[0].dr; bf_dc = q[0].dc;
                if (bf_resp_rdy) void'(q.pop_front());
            end else begin
                bf_resp_val = 1'b0;
                bf_cr = $urandom; bf_cc = $urandom; bf_dr = $urandom; bf_dc = $urandom;
            end
            bf_req_rdy = ($urandom_range(99) < p_req);
            st_r = bf_req_val && !bf_req_rdy;
            if (st_r) begin
                sv_tw = tw_idx; sv_ar = bf_ar; sv_ac = bf_ac; sv_br = bf_br; sv_bc = bf_bc;
            end
            if (bf_req_val && bf_req_rdy) begin
                chk("req_in_range", (kreq < SIZE/2), 1);
                if (kreq < SIZE/2) begin
                    chk("req_tw_idx", tw_idx, exp_tw[kreq]);
                    chk("req_ar", bf_ar, in_r[exp_ia[kreq]]);
                    chk("req_ac", bf_ac, in_c[exp_ia[kreq]]);
                    chk("req_br", bf_br, in_r[exp_ib[kreq]]);
                    chk("req_bc", bf_bc, in_c[exp_ib[kreq]]);
                    chk("req_wr", bf_wr, tbl_r[exp_tw[kreq]]);
                    chk("req_wc", bf_wc, tbl_c[exp_tw[kreq]]);
                end
                bfly(bf_ar, bf_ac, bf_br, bf_bc, bf_wr, bf_wc, e.cr, e.cc, e.dr, e.dc);
                e.t = cyc + lat;
                q.push_back(e);
                kreq++;
            end
            send_rdy = ($urandom_range(99) < p_send);
            st_s = send_val && !send_rdy;
            if (st_s) begin
                sv_sr = send_r; sv_sc = send_c;
            end
            if (send_val && send_rdy) begin
                chk("send_r", send_r, gold_r[outn]);
                chk("send_c", send_c, gold_c[outn]);
                got_r[outn] = send_r;
                got_c[outn] = send_c;
                outn++;
            end
            cyc++;
        end
        last_cycles = cyc;
    endtask

    initial begin
        int dir_r [SIZE] = '{4, 2, -2, 2, 12, 6, -2, 6};
        int dir_c [SIZE] = '{0, -4, 0, 4, 0, -8, 0, 8};
        logic [N-1:0] ev;

        reset = 1'b1;
        recv_val = 0; recv_r = 0; recv_c = 0;
        send_rdy = 0; bf_req_rdy = 0; bf_resp_val = 0;
        bf_cr = 0; bf_cc = 0; bf_dr = 0; bf_dc = 0;
        fill_random();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;

        // Directed: w0 = 1.0, w2 = -j; pos-1 pairs pick up the -j twiddle.
        for (int i = 0; i < SIZE; i++) begin
            in_r[i] = (i + 1) * 65536;
            in_c[i] = 0;
        end
        tbl_r[0] = 32'h0001_0000; tbl_c[0] = 0;
        tbl_r[2] = 0;             tbl_c[2] = 32'hFFFF_0000;
        run_block(1, 100, 100, 100, 0);
        chk("min_block_cycles", last_cycles, SIZE + SIZE/2 + 1 + SIZE);
        for (int i = 0; i < SIZE; i++) begin
            ev = dir_r[i] * 65536;
            chk("directed_r", got_r[i], ev);
            ev = dir_c[i] * 65536;
            chk("directed_c", got_c[i], ev);
        end

        fill_random();
        run_block(3, 100, 100, 100, 0);
        chk("outstanding_ge3", (max_out >= 3), 1);

        fill_random();
        run_block(3, 100, 60, 100, 0);

        for (int b = 0; b < 4; b++) begin
            fill_random();
            run_block($urandom_range(4, 1), 60, 70, 55, 0);
        end

        // Abort mid-COMPUTE with two requests outstanding.
        fill_random();
        run_block(5, 100, 100, 100, 2);
        chk("abort_reached", aborted, 1);
        reset = 1'b1;
        recv_val = 0; send_rdy = 0; bf_req_rdy = 0; bf_resp_val = 0;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs();
        bf_resp_val = 1'b1;
        bf_cr = $urandom; bf_cc = $urandom; bf_dr = $urandom; bf_dc = $urandom;
        repeat (3) begin
            @(negedge clk);
            chk("late_resp_not_acked", bf_resp_rdy, 0);
        end
        bf_resp_val = 1'b0;
        fill_random();
        run_block(2, 80, 80, 80, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
